wb_scheduler: RTL and testbench

- Owns the single register-file write port in the miniRV core.
- Shares that port between same-cycle execute results (ALU, PC+4, U-immediate) and one outstanding variable-latency load.
- Drives wb_sel for the downstream writeback mux, plus rf_we/rf_waddr.
- Stalls the execute stage on load-use, WAW and write-port hazards, and watchdogs the outstanding load.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_hazard_unit.sv | 38 +++
 rtl/wb_scheduler.sv | 111 +++++++++++
 tb/tb_wb_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback scheduler: mux selects, FSM states and fault codes.
package wb_pkg;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_RESP,
      ERR
   } wb_state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0] ERR_SPURIOUS = 2'b10;

endpackage

// File: rtl/wb_hazard_unit.sv
// Combinational execute-stage stall while a load is outstanding: second load, RAW, WAW and
// write-port conflict with the returning load.
module wb_hazard_unit
   import wb_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic              ex_valid,
   input  logic [1:0]        ex_wb_src,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic              ex_rs1_used,
   input  logic              ex_rs2_used,
   input  logic [REG_AW-1:0] pend_rd,
   input  logic              ld_pending,
   input  logic              mem_rvalid,
   output logic              stall
);

   logic is_load;
   logic rd_nz;
   logic raw;
   logic waw;
   logic port_conflict;

   always_comb begin
      is_load       = (ex_wb_src == WB_MEM);
      rd_nz         = (ex_rd != '0);
      raw           = (pend_rd != '0) &&
                      ((ex_rs1_used && (ex_rs1 == pend_rd)) ||
                       (ex_rs2_used && (ex_rs2 == pend_rd)));
      waw           = !is_load && rd_nz && (ex_rd == pend_rd);
      port_conflict = mem_rvalid && !is_load && rd_nz;
      stall         = ld_pending && ex_valid && (is_load || raw || waw || port_conflict);
   end

endmodule

// File: rtl/wb_scheduler.sv
// Register-file write-port owner: merges execute results with one outstanding load,
// stalls execute on hazards and watchdogs the load.
module wb_scheduler
   import wb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned REG_AW  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [1:0]        ex_wb_src,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic              ex_rs1_used,
   input  logic              ex_rs2_used,
   input  logic              mem_rvalid,
   output logic              ex_ready,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [1:0]        wb_sel,
   output logic              ld_pending,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   wb_state_t         fsm;
   logic [REG_AW-1:0] pend_rd;
   logic [TW-1:0]     timer;
   logic [1:0]        err_code_q;

   logic stall;
   logic ex_is_load;
   logic ex_wr;
   logic ld_wr;

   wb_hazard_unit #(
      .REG_AW (REG_AW)
   ) u_hazard (
      .ex_valid    (ex_valid),
      .ex_wb_src   (ex_wb_src),
      .ex_rd       (ex_rd),
      .ex_rs1      (ex_rs1),
      .ex_rs2      (ex_rs2),
      .ex_rs1_used (ex_rs1_used),
      .ex_rs2_used (ex_rs2_used),
      .pend_rd     (pend_rd),
      .ld_pending  (ld_pending),
      .mem_rvalid  (mem_rvalid),
      .stall       (stall)
   );

   always_comb begin
      ld_pending = (fsm == WAIT_RESP);
      err        = (fsm == ERR);
      err_code   = err_code_q;
      ex_is_load = (ex_wb_src == WB_MEM);
      ex_ready   = !err && !stall;
      ex_wr      = ex_valid && ex_ready && !ex_is_load && (ex_rd != '0);
      ld_wr      = ld_pending && mem_rvalid && (pend_rd != '0);
      rf_we      = ex_wr || ld_wr;
      rf_waddr   = '0;
      wb_sel     = WB_ALU;
      // Hazard logic guarantees ex_wr and ld_wr are never both set.
      if (ld_wr) begin
         rf_waddr = pend_rd;
         wb_sel   = WB_MEM;
      end else if (ex_wr) begin
         rf_waddr = ex_rd;
         wb_sel   = ex_wb_src;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm        <= IDLE;
         pend_rd    <= '0;
         timer      <= '0;
         err_code_q <= ERR_NONE;
      end else begin
         unique case (fsm)
            IDLE: begin
               if (mem_rvalid) begin
                  fsm        <= ERR;
                  err_code_q <= ERR_SPURIOUS;
               end else if (ex_valid && ex_is_load) begin
                  fsm     <= WAIT_RESP;
                  pend_rd <= ex_rd;
                  timer   <= '0;
               end
            end
            WAIT_RESP: begin
               if (mem_rvalid) begin
                  fsm <= IDLE;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  fsm        <= ERR;
                  err_code_q <= ERR_TIMEOUT;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ERR: fsm <= ERR;
            default: fsm <= ERR;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed scoreboard bench for wb_scheduler: the driver queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_wb_scheduler;

   localparam int unsigned TIMEOUT = 4;
   localparam int unsigned REG_AW  = 5;

   typedef struct packed {
      logic       ready;
      logic       we;
      logic [4:0] waddr;
      logic [1:0] sel;
      logic       ldp;
      logic       err;
      logic [1:0] code;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ex_valid = 1'b0;
   logic [1:0]        ex_wb_src = 2'b00;
   logic [REG_AW-1:0] ex_rd = '0;
   logic [REG_AW-1:0] ex_rs1 = '0;
   logic [REG_AW-1:0] ex_rs2 = '0;
   logic              ex_rs1_used = 1'b0;
   logic              ex_rs2_used = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic              ex_ready;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [1:0]        wb_sel;
   logic              ld_pending;
   logic              err;
   logic [1:0]        err_code;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc_no  = 0;

   wb_scheduler #(
      .TIMEOUT (TIMEOUT),
      .REG_AW  (REG_AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid    (ex_valid),
      .ex_wb_src   (ex_wb_src),
      .ex_rd       (ex_rd),
      .ex_rs1      (ex_rs1),
      .ex_rs2      (ex_rs2),
      .ex_rs1_used (ex_rs1_used),
      .ex_rs2_used (ex_rs2_used),
      .mem_rvalid  (mem_rvalid),
      .ex_ready    (ex_ready),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .wb_sel      (wb_sel),
      .ld_pending  (ld_pending),
      .err         (err),
      .err_code    (err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL cycle %0d %s: got %0d expected %0d", cyc_no, name, act, req);
      end
   endtask

   // Monitor: one expected entry per driven cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("ex_ready",   {4'b0, ex_ready},   {4'b0, e.ready});
         check("rf_we",      {4'b0, rf_we},      {4'b0, e.we});
         check("rf_waddr",   rf_waddr,           e.waddr);
         check("wb_sel",     {3'b0, wb_sel},     {3'b0, e.sel});
         check("ld_pending", {4'b0, ld_pending}, {4'b0, e.ldp});
         check("err",        {4'b0, err},        {4'b0, e.err});
         check("err_code",   {3'b0, err_code},   {3'b0, e.code});
         cyc_no++;
      end
   end

   // One cycle: v src rd rs1 u1 rv r | expected ready we waddr sel ldp err code.
   task automatic cyc(input logic v, input logic [1:0] src, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic u1, input logic rv, input logic r,
                      input logic e_rdy, input logic e_we, input logic [4:0] e_wa,
                      input logic [1:0] e_sel, input logic e_ldp, input logic e_err,
                      input logic [1:0] e_code);
      exp_t e;
      @(posedge clk);
      #1;
      ex_valid    = v;
      ex_wb_src   = src;
      ex_rd       = rd;
      ex_rs1      = rs1;
      ex_rs1_used = u1;
      ex_rs2      = 5'd0;
      ex_rs2_used = 1'b0;
      mem_rvalid  = rv;
      rst         = r;
      e = '{ready: e_rdy, we: e_we, waddr: e_wa, sel: e_sel, ldp: e_ldp, err: e_err,
            code: e_code};
      exp_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      //   v  src   rd  rs1 u1 rv r   rdy we wa sel ldp err code
      cyc(0, 2'd0, 0, 0, 0, 0, 1,  1, 0, 0, 2'd0, 0, 0, 2'd0); // reset values
      cyc(1, 2'd0, 5, 0, 0, 0, 0,  1, 1, 5, 2'd0, 0, 0, 2'd0); // ALU rd=5
      cyc(1, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0); // ALU rd=0
      cyc(1, 2'd2, 3, 0, 0, 0, 0,  1, 1, 3, 2'd2, 0, 0, 2'd0); // PC+4 rd=3
      cyc(1, 2'd1, 7, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0); // load rd=7
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 1, 0,  1, 1, 7, 2'd1, 1, 0, 2'd0); // response
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      // RAW stall and independent issue
      cyc(1, 2'd1, 7, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      cyc(1, 2'd0, 9, 8, 1, 0, 0,  1, 1, 9, 2'd0, 1, 0, 2'd0);
      cyc(1, 2'd0, 10, 7, 1, 0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(1, 2'd0, 10, 7, 1, 1, 0, 0, 1, 7, 2'd1, 1, 0, 2'd0);
      cyc(1, 2'd0, 10, 7, 1, 0, 0, 1, 1, 10, 2'd0, 0, 0, 2'd0);
      // Port conflict: load wins
      cyc(1, 2'd1, 7, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      cyc(1, 2'd0, 9, 0, 0, 1, 0,  0, 1, 7, 2'd1, 1, 0, 2'd0);
      cyc(1, 2'd0, 9, 0, 0, 0, 0,  1, 1, 9, 2'd0, 0, 0, 2'd0);
      // WAW and second-load stalls
      cyc(1, 2'd1, 7, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      cyc(1, 2'd0, 7, 0, 0, 0, 0,  0, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(1, 2'd1, 3, 0, 0, 0, 0,  0, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 1, 0,  1, 1, 7, 2'd1, 1, 0, 2'd0);
      // Load to x0 still tracked, response not written
      cyc(1, 2'd1, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 1, 0,  1, 0, 0, 2'd0, 1, 0, 2'd0);
      // Response in the last allowed cycle completes normally
      cyc(1, 2'd1, 4, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 1, 0,  1, 1, 4, 2'd1, 1, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      // Timeout
      cyc(1, 2'd1, 6, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  0, 0, 0, 2'd0, 0, 1, 2'd1);
      cyc(1, 2'd0, 5, 0, 0, 1, 0,  0, 0, 0, 2'd0, 0, 1, 2'd1); // ERR ignores everything
      cyc(0, 2'd0, 0, 0, 0, 0, 1,  0, 0, 0, 2'd0, 0, 1, 2'd1);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      // Spurious response in IDLE
      cyc(0, 2'd0, 0, 0, 0, 1, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  0, 0, 0, 2'd0, 0, 1, 2'd2);
      cyc(0, 2'd0, 0, 0, 0, 0, 1,  0, 0, 0, 2'd0, 0, 1, 2'd2);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      // Reset mid-load; late response is spurious
      cyc(1, 2'd1, 7, 0, 0, 0, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 1,  1, 0, 0, 2'd0, 1, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 1, 0,  1, 0, 0, 2'd0, 0, 0, 2'd0);
      cyc(0, 2'd0, 0, 0, 0, 0, 0,  0, 0, 0, 2'd0, 0, 1, 2'd2);
      @(posedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
